cla_adder_arbiter: RTL and testbench
====================================

Name: cla_adder_arbiter

Overview:
Round-robin scheduler that shares one pipelined carry-lookahead adder (WIDTH-bit operands, WIDTH+1-bit result) among NUM_REQ requesters. It accepts at most one operand pair per cycle through valid/ready handshakes and drives the adder operand inputs. A tag pipeline matched to the adder latency routes each sum back with its requester ID. It sits between client blocks and the adder instance; the adder itself is external.

Parameters:
WIDTH, 8, operand width; result is WIDTH+1
NUM_REQ, 4, number of requesters; legal 2..8
LATENCY, 2, adder latency in cycles from operand change to valid i_result; legal 0..4 (0 = combinational adder)
ID_W, derived localparam = max(1, clog2(NUM_REQ))

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_add1  in  NUM_REQ*WIDTH  operand A, requester r at [r*WIDTH +: WIDTH]
i_req_add2  in  NUM_REQ*WIDTH  operand B, same packing
o_req_ready  out  NUM_REQ  one-hot grant (combinational)
i_hold  in  1  when 1, no new grants
o_add1  out  WIDTH  registered operand A to adder
o_add2  out  WIDTH  registered operand B to adder
i_result  in  WIDTH+1  adder sum
o_rsp_valid  out  1  one-cycle pulse per completed operation
o_rsp_id  out  ID_W  requester index of the response
o_rsp_sum  out  WIDTH+1  sum of the response
o_busy  out  1  operations in flight
o_issue_cnt  out  16  total accepted requests

Behaviour:
- Reset (rst=0, asynchronous): o_add1/o_add2=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_sum=0, o_issue_cnt=0, rr pointer=0, all tag stages invalid, o_req_ready=0 while rst=0. In-flight operations are dropped; no response pulses for them after release.
- Arbitration (combinational): if rst=1 and i_hold=0, grant the first r with i_req_valid[r]=1, searching ptr, ptr+1, ... with wrap at NUM_REQ. o_req_ready is one-hot or zero. o_req_ready does not depend on o_rsp or back-pressure. Responses have no ready signal.
- Transfer: i_req_valid[r] & o_req_ready[r] at edge E0. At E0: o_add1/o_add2 <= operands of r; ptr <= (r+1) mod NUM_REQ; o_issue_cnt += 1, wrapping 65535->0; a tag {valid=1, id=r} enters stage 0. With no transfer, ptr and o_add* hold their values, and an invalid tag enters.
- Tag pipeline: LATENCY+1 stages shift every cycle. The final stage registers o_rsp_valid, o_rsp_id, and o_rsp_sum<=i_result at edge E0+LATENCY+1. Response latency is LATENCY+1 cycles after the handshake edge.
- Throughput: one issue per cycle. Responses return in issue order, back to back, with no gaps for back-to-back issues.
- When o_rsp_valid=0, o_rsp_id and o_rsp_sum hold their last values.
- Sum is full WIDTH+1 bits; carry lands in bit WIDTH with no truncation or saturation.
- o_busy = OR of all tag valid bits; o_rsp_valid itself is excluded.
- i_hold asserted mid-stream: new grants stop the same cycle. In-flight operations complete normally. ptr is unchanged.
- Simultaneous events: a new issue and a response in the same cycle are independent. Requests dropping valid without a grant are legal and are not remembered.

Test Plan:
WIDTH=8, NUM_REQ=4, LATENCY=2 unless stated.
1. Hold rst=0 with all valids high -> o_req_ready=0 and all outputs 0. Release rst -> first grant goes to requester 0.
2. Only req1 valid, a=10, b=7 for one cycle -> o_req_ready=4'b0010 that cycle; o_rsp_valid pulses 3 cycles after the handshake edge with o_rsp_id=1, o_rsp_sum=17; o_busy high for exactly 3 cycles.
3. All four valid continuously with operands (r, 10r) -> grants 0,1,2,3,0,... one per cycle; responses back to back with ids 0,1,2,3 and sums 0,11,22,33; o_issue_cnt increments each cycle.
4. Overflow: 200+100 -> o_rsp_sum=300 (9'h12C); 255+255 -> 510. Repeat with LATENCY=0 -> response 1 cycle after the handshake.
5. i_hold=1 for 5 cycles while req2 and req3 are pending, after 2 issues -> o_req_ready=0 during hold; both in-flight responses still arrive; o_busy falls; on release, grant resumes from the saved ptr.
6. Pull rst low with 2 operations in flight, release after 1 cycle -> no o_rsp_valid pulse for them; o_issue_cnt=0, o_busy=0.

Source files
------------

// File: rtl/cla_adder_arbiter.sv
// rtl/cla_adder_arbiter.sv - round-robin front end sharing one pipelined adder among requesters
// Tags travel alongside the adder pipeline so each sum returns with its requester index.
module cla_adder_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_add2,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_hold,
    output logic [WIDTH-1:0]           o_add1,
    output logic [WIDTH-1:0]           o_add2,
    input  logic [WIDTH:0]             i_result,
    output logic                       o_rsp_valid,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic [WIDTH:0]             o_rsp_sum,
    output logic                       o_busy,
    output logic [15:0]                o_issue_cnt
);

    localparam int STAGES = LATENCY + 1;

    logic [ID_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_id;
    logic              found;
    logic              xfer;
    int                idx;

    logic [STAGES-1:0] tag_valid;
    logic [ID_W-1:0]   tag_id [STAGES];

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        if (rst && !i_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!found && i_req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                    found      = 1'b1;
                end
            end
        end
    end

    assign o_req_ready = grant;
    assign xfer        = found;
    assign o_busy      = |tag_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            o_add1      <= '0;
            o_add2      <= '0;
            o_issue_cnt <= '0;
            tag_valid   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_id[s] <= '0;
            end
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
        end else begin
            if (xfer) begin
                o_add1      <= i_req_add1[int'(grant_id)*WIDTH +: WIDTH];
                o_add2      <= i_req_add2[int'(grant_id)*WIDTH +: WIDTH];
                o_issue_cnt <= o_issue_cnt + 16'd1;
                if (int'(grant_id) == NUM_REQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_id + 1'b1;
                end
            end
            tag_valid[0] <= xfer;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < STAGES; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            // The last tag stage lines up with the cycle the adder sum for that issue is valid.
            o_rsp_valid <= tag_valid[STAGES-1];
            if (tag_valid[STAGES-1]) begin
                o_rsp_id  <= tag_id[STAGES-1];
                o_rsp_sum <= i_result;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// tb/tb_cla_adder_arbiter.sv - directed checks of cla_adder_arbiter with LATENCY=2 and LATENCY=0 adders
module tb_cla_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_add1;
    logic [31:0] req_add2;
    logic        hold;

    logic [3:0]  ready_a, ready_b;
    logic [7:0]  add1_a, add2_a, add1_b, add2_b;
    logic [8:0]  result_a, result_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [1:0]  rsp_id_a, rsp_id_b;
    logic [8:0]  rsp_sum_a, rsp_sum_b;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a, cnt_b;

    logic [8:0]  pipe1, pipe2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_adder_arbiter #(.WIDTH(8), .NUM_REQ(4), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_add1(req_add1),
        .i_req_add2(req_add2), .o_req_ready(ready_a), .i_hold(hold),
        .o_add1(add1_a), .o_add2(add2_a), .i_result(result_a),
        .o_rsp_valid(rsp_valid_a), .o_rsp_id(rsp_id_a), .o_rsp_sum(rsp_sum_a),
        .o_busy(busy_a), .o_issue_cnt(cnt_a)
    );

    cla_adder_arbiter #(.WIDTH(8), .NUM_REQ(4), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_add1(req_add1),
        .i_req_add2(req_add2), .o_req_ready(ready_b), .i_hold(hold),
        .o_add1(add1_b), .o_add2(add2_b), .i_result(result_b),
        .o_rsp_valid(rsp_valid_b), .o_rsp_id(rsp_id_b), .o_rsp_sum(rsp_sum_b),
        .o_busy(busy_b), .o_issue_cnt(cnt_b)
    );

    // External adders: two-stage pipelined for dut_a, combinational for dut_b.
    always_ff @(posedge clk) begin
        pipe1 <= {1'b0, add1_a} + {1'b0, add2_a};
        pipe2 <= pipe1;
    end
    assign result_a = pipe2;
    assign result_b = {1'b0, add1_b} + {1'b0, add2_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b);
        req_add1[r*8 +: 8] = a;
        req_add2[r*8 +: 8] = b;
    endtask

    initial begin
        logic [3:0] exp_grant;
        int         id;

        rst       = 1'b0;
        req_valid = 4'hF;
        req_add1  = 32'h0;
        req_add2  = 32'h0;
        hold      = 1'b0;

        // Reset state with every requester asking
        tick();
        tick();
        check("rst_ready", ready_a, 4'b0000);
        check("rst_add1", add1_a, 0);
        check("rst_add2", add2_a, 0);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_id", rsp_id_a, 0);
        check("rst_rsp_sum", rsp_sum_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_cnt", cnt_a, 0);
        rst = 1'b1;
        #1;
        check("first_grant", ready_a, 4'b0001);
        req_valid = 4'b0000;
        #1;

        // Single request from requester 1: 10 + 7
        set_ops(1, 8'd10, 8'd7);
        req_valid = 4'b0010;
        #1;
        check("single_ready", ready_a, 4'b0010);
        tick();
        req_valid = 4'b0000;
        check("single_add1", add1_a, 10);
        check("single_add2", add2_a, 7);
        check("single_cnt", cnt_a, 1);
        check("single_busy0", busy_a, 1);
        check("single_rsp0", rsp_valid_a, 0);
        tick();
        check("single_busy1", busy_a, 1);
        check("single_rsp1", rsp_valid_a, 0);
        check("single_b_valid", rsp_valid_b, 1);
        check("single_b_sum", rsp_sum_b, 17);
        tick();
        check("single_busy2", busy_a, 1);
        check("single_rsp2", rsp_valid_a, 0);
        tick();
        check("single_rsp_valid", rsp_valid_a, 1);
        check("single_rsp_id", rsp_id_a, 1);
        check("single_rsp_sum", rsp_sum_a, 17);
        check("single_busy3", busy_a, 0);
        tick();
        check("single_pulse_end", rsp_valid_a, 0);
        check("single_id_hold", rsp_id_a, 1);
        check("single_sum_hold", rsp_sum_a, 17);

        // All four streaming with operands (r, 10r); ptr is 2 after the single issue
        for (int r = 0; r < 4; r++) set_ops(r, 8'(r), 8'(10 * r));
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 6) ? 4'hF : 4'h0;
            #1;
            exp_grant = (k < 6) ? 4'(1 << ((2 + k) % 4)) : 4'b0000;
            check("stream_ready", ready_a, exp_grant);
            tick();
            if (k < 6) check("stream_cnt", cnt_a, 2 + k);
            if (k >= 3) begin
                id = (2 + k - 3) % 4;
                check("stream_rsp_valid", rsp_valid_a, 1);
                check("stream_rsp_id", rsp_id_a, id);
                check("stream_rsp_sum", rsp_sum_a, 11 * id);
            end else begin
                check("stream_rsp_idle", rsp_valid_a, 0);
            end
        end
        tick();
        check("stream_done_valid", rsp_valid_a, 0);
        check("stream_done_busy", busy_a, 0);
        check("stream_total", cnt_a, 7);

        // Carry into bit 8; ptr is 0, only requester 0 asks twice
        set_ops(0, 8'd200, 8'd100);
        req_valid = 4'b0001;
        #1;
        check("ovf_ready0", ready_a, 4'b0001);
        tick();
        set_ops(0, 8'd255, 8'd255);
        #1;
        check("ovf_ready1", ready_a, 4'b0001);
        tick();
        req_valid = 4'b0000;
        check("ovf_b_valid0", rsp_valid_b, 1);
        check("ovf_b_sum0", rsp_sum_b, 9'h12C);
        check("ovf_a_wait", rsp_valid_a, 0);
        tick();
        check("ovf_b_valid1", rsp_valid_b, 1);
        check("ovf_b_sum1", rsp_sum_b, 510);
        tick();
        check("ovf_a_valid0", rsp_valid_a, 1);
        check("ovf_a_sum0", rsp_sum_a, 300);
        check("ovf_b_idle", rsp_valid_b, 0);
        tick();
        check("ovf_a_valid1", rsp_valid_a, 1);
        check("ovf_a_sum1", rsp_sum_a, 510);
        check("ovf_cnt", cnt_a, 9);

        // Two issues to req2/req3, then hold five cycles with both still asking
        set_ops(2, 8'd2, 8'd20);
        set_ops(3, 8'd3, 8'd30);
        req_valid = 4'b1100;
        #1;
        check("hold_pre_ready2", ready_a, 4'b0100);
        tick();
        check("hold_pre_ready3", ready_a, 4'b1000);
        tick();
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_ready", ready_a, 4'b0000);
            tick();
            if (k == 0) check("hold_busy", busy_a, 1);
            if (k == 1) begin
                check("hold_rsp2_valid", rsp_valid_a, 1);
                check("hold_rsp2_id", rsp_id_a, 2);
                check("hold_rsp2_sum", rsp_sum_a, 22);
            end
            if (k == 2) begin
                check("hold_rsp3_valid", rsp_valid_a, 1);
                check("hold_rsp3_id", rsp_id_a, 3);
                check("hold_rsp3_sum", rsp_sum_a, 33);
                check("hold_busy_fall", busy_a, 0);
            end
        end
        check("hold_cnt", cnt_a, 11);
        hold = 1'b0;
        #1;
        check("hold_resume", ready_a, 4'b0100);
        req_valid = 4'b0000;
        #1;

        // Reset with two operations in flight; ptr would be 2 if not cleared
        set_ops(0, 8'd1, 8'd2);
        set_ops(1, 8'd3, 8'd4);
        req_valid = 4'b0011;
        tick();
        tick();
        req_valid = 4'b0000;
        check("flight_busy", busy_a, 1);
        rst = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_cnt", cnt_a, 0);
        check("arst_add1", add1_a, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("arst_no_rsp", rsp_valid_a, 0);
        end
        check("arst_cnt_after", cnt_a, 0);
        check("arst_busy_after", busy_a, 0);
        req_valid = 4'b0110;
        #1;
        check("arst_ptr", ready_a, 4'b0010);
        req_valid = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
